conv_sched: RTL and testbench

Sequencer for the `ConvLayer` 3x3 convolution datapath. It runs the layer over `NumKernels` kernels in turn. For each kernel it:
- fetches the 9 kernel weights from the weight memory and streams them into `weight_in`/`weight_valid`;
- gates a stream of 3x3 windows from upstream into `window_in`/`window_valid`;
- waits for every result of that kernel to drain before reloading weights.

It sits between the window buffer and weight RAM on one side and `ConvLayer` on the other.

---
 rtl/conv_pkg.sv | 30 +++
 rtl/weight_fetch.sv | 56 +++++
 rtl/conv_sched.sv | 173 +++++++++++++++++
 tb/tb_conv_sched.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the conv_sched sequencer.
//   - state encoding for the job FSM
//   - KWORDS: number of weights per 3x3 kernel
//   - clog2: ceiling log2 helper for parameter-derived widths
package conv_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_STREAM = 3'd2;
  localparam state_t ST_DRAIN  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  localparam int KWORDS = 9;

  // Ceiling log2; clog2(1) = 0, callers clamp widths to at least 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/weight_fetch.sv
// weight_fetch: issues the KWORDS weight-memory reads for one kernel.
// Ports:
//   Clk, Rst_n    clock, asynchronous active-low reset
//   go            pulse: begin a 9-read burst
//   wmem_rd       read strobe, high for exactly KWORDS cycles
//   addr_inc      advance the caller's address counter (one per read)
//   weight_valid  wmem_rd delayed one cycle, aligned with memory data
//   fin           pulse coincident with the last weight_valid
module weight_fetch
  import conv_pkg::*;
(
  input  logic Clk,
  input  logic Rst_n,
  input  logic go,
  output logic wmem_rd,
  output logic addr_inc,
  output logic weight_valid,
  output logic fin
);

  logic [3:0] rd_cnt_reg;
  logic       rd_reg;
  logic       valid_reg;
  logic       last_reg;
  logic       last_rd;

  assign last_rd = rd_reg && (rd_cnt_reg == 4'(KWORDS - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_cnt_reg <= '0;
      rd_reg     <= 1'b0;
      valid_reg  <= 1'b0;
      last_reg   <= 1'b0;
    end else begin
      if (go) begin
        rd_reg     <= 1'b1;
        rd_cnt_reg <= '0;
      end else if (rd_reg) begin
        rd_cnt_reg <= rd_cnt_reg + 4'd1;
        if (last_rd) begin
          rd_reg <= 1'b0;
        end
      end
      valid_reg <= rd_reg;
      // Delaying the last-read flag with the strobe marks the final valid word.
      last_reg  <= last_rd;
    end
  end

  assign wmem_rd      = rd_reg;
  assign addr_inc     = rd_reg;
  assign weight_valid = valid_reg;
  assign fin          = last_reg;

endmodule

// File: rtl/conv_sched.sv
// conv_sched: sequences a 3x3 ConvLayer over NumKernels kernels. For each
// kernel it loads 9 weights from weight memory, gates num_windows windows from
// upstream, then waits for every result to drain before the next kernel.
// Ports:
//   Clk, Rst_n                  clock, asynchronous active-low reset
//   start, num_windows          job start (ignored while busy), windows per kernel
//   busy, done, kernel_idx      job status
//   wmem_rd, wmem_addr, wmem_data   weight memory (1-cycle read latency)
//   win_in, win_in_valid, win_in_ready   upstream window stream
//   weight_out, weight_valid    to ConvLayer weight port
//   window_out, window_valid    to ConvLayer window port
//   result_valid                from ConvLayer, counted for drain detection
module conv_sched
  import conv_pkg::*;
#(
  parameter  int DataWidth  = 32,
  parameter  int NumKernels = 4,
  parameter  int WAddrWidth = 8,
  parameter  int CntWidth   = 16,
  localparam int KIdxWidth  = (clog2(NumKernels) < 1) ? 1 : clog2(NumKernels)
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   start,
  input  logic [CntWidth-1:0]    num_windows,
  output logic                   busy,
  output logic                   done,
  output logic [KIdxWidth-1:0]   kernel_idx,
  output logic                   wmem_rd,
  output logic [WAddrWidth-1:0]  wmem_addr,
  input  logic [DataWidth-1:0]   wmem_data,
  input  logic [9*DataWidth-1:0] win_in,
  input  logic                   win_in_valid,
  output logic                   win_in_ready,
  output logic [DataWidth-1:0]   weight_out,
  output logic                   weight_valid,
  output logic [9*DataWidth-1:0] window_out,
  output logic                   window_valid,
  input  logic                   result_valid
);

  state_t                state_reg;
  state_t                state_next;
  logic [CntWidth-1:0]   num_win_reg;
  logic [CntWidth-1:0]   win_cnt_reg;
  logic [CntWidth-1:0]   win_cnt_inc;
  logic [CntWidth-1:0]   res_cnt_reg;
  logic [KIdxWidth-1:0]  kernel_idx_reg;
  logic [WAddrWidth-1:0] wmem_addr_reg;

  logic go;
  logic fin;
  logic addr_inc;
  logic job_accept;
  logic win_accept;
  logic last_win;
  logic drain_done;
  logic last_kernel;
  logic counting;

  weight_fetch u_weight_fetch (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .go           (go),
    .wmem_rd      (wmem_rd),
    .addr_inc     (addr_inc),
    .weight_valid (weight_valid),
    .fin          (fin)
  );

  assign job_accept  = (state_reg == ST_IDLE) && start && (num_windows != '0);
  assign win_accept  = win_in_valid && win_in_ready;
  assign win_cnt_inc = win_cnt_reg + CntWidth'(1);
  assign last_win    = win_accept && (win_cnt_inc == num_win_reg);
  assign drain_done  = (state_reg == ST_DRAIN) && (res_cnt_reg == num_win_reg);
  assign last_kernel = (kernel_idx_reg == KIdxWidth'(NumKernels - 1));
  // Results are only meaningful once windows have been issued for this kernel.
  assign counting    = (state_reg == ST_STREAM) || (state_reg == ST_DRAIN);

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (num_windows != '0) ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        if (fin) begin
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last_win) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_next = last_kernel ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    win_in_ready = (state_reg == ST_STREAM);
    done         = (state_reg == ST_DONE);
    busy         = (state_reg != ST_IDLE);
    go           = job_accept || (drain_done && !last_kernel);
  end

  // Counters, kernel index and weight address
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      num_win_reg    <= '0;
      win_cnt_reg    <= '0;
      res_cnt_reg    <= '0;
      kernel_idx_reg <= '0;
      wmem_addr_reg  <= '0;
    end else if (job_accept) begin
      num_win_reg    <= num_windows;
      win_cnt_reg    <= '0;
      res_cnt_reg    <= '0;
      kernel_idx_reg <= '0;
      wmem_addr_reg  <= '0;
    end else begin
      // The address runs on across kernels, so kernel k lands on 9k..9k+8.
      if (addr_inc) begin
        wmem_addr_reg <= wmem_addr_reg + WAddrWidth'(1);
      end
      if (drain_done) begin
        win_cnt_reg <= '0;
        res_cnt_reg <= '0;
        if (!last_kernel) begin
          kernel_idx_reg <= kernel_idx_reg + KIdxWidth'(1);
        end
      end else begin
        if (win_accept) begin
          win_cnt_reg <= win_cnt_inc;
        end
        if (counting && result_valid && (res_cnt_reg != num_win_reg)) begin
          res_cnt_reg <= res_cnt_reg + CntWidth'(1);
        end
      end
    end
  end

  assign kernel_idx   = kernel_idx_reg;
  assign wmem_addr    = wmem_addr_reg;
  // Gated so the weight port reads zero whenever no weight is being presented.
  assign weight_out   = weight_valid ? wmem_data : '0;
  assign window_out   = win_in;
  assign window_valid = win_accept;

endmodule

// File: tb/tb_conv_sched.sv
module tb_conv_sched;

  localparam int DW = 32;
  localparam int NK = 2;
  localparam int AW = 8;
  localparam int CW = 16;
  localparam int KW = 1;

  logic            Clk = 1'b0;
  logic            Rst_n = 1'b0;
  logic            start = 1'b0;
  logic [CW-1:0]   num_windows = '0;
  logic            busy;
  logic            done;
  logic [KW-1:0]   kernel_idx;
  logic            wmem_rd;
  logic [AW-1:0]   wmem_addr;
  logic [DW-1:0]   wmem_data = '0;
  logic [9*DW-1:0] win_in = '0;
  logic            win_in_valid = 1'b0;
  logic            win_in_ready;
  logic [DW-1:0]   weight_out;
  logic            weight_valid;
  logic [9*DW-1:0] window_out;
  logic            window_valid;
  logic            result_valid;

  conv_sched #(
    .DataWidth  (DW),
    .NumKernels (NK),
    .WAddrWidth (AW),
    .CntWidth   (CW)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .start        (start),
    .num_windows  (num_windows),
    .busy         (busy),
    .done         (done),
    .kernel_idx   (kernel_idx),
    .wmem_rd      (wmem_rd),
    .wmem_addr    (wmem_addr),
    .wmem_data    (wmem_data),
    .win_in       (win_in),
    .win_in_valid (win_in_valid),
    .win_in_ready (win_in_ready),
    .weight_out   (weight_out),
    .weight_valid (weight_valid),
    .window_out   (window_out),
    .window_valid (window_valid),
    .result_valid (result_valid)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  // Weight memory model: one-cycle read latency.
  logic [DW-1:0] wmem [0:255];
  always @(posedge Clk) if (wmem_rd) wmem_data <= wmem[wmem_addr];

  // ConvLayer model: one result 4 cycles after each issued window.
  logic [3:0] pipe = '0;
  logic       stray_rv = 1'b0;
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) pipe <= '0;
    else        pipe <= {pipe[2:0], window_valid};
  end
  assign result_valid = pipe[3] | stray_rv;

  // Event counters (sampled mid-cycle, equal to what the next edge sees).
  int n_rd = 0, n_win = 0, n_res = 0, n_done = 0;
  logic [DW-1:0] wq[$];

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (wmem_rd)      n_rd++;
      if (window_valid) n_win++;
      if (pipe[3])      n_res++;
      if (done)         n_done++;
      if (window_valid) begin
        total++;
        if (window_out !== win_in) begin
          bad++;
          $display("FAIL window_pass got=%h want=%h", window_out, win_in);
        end
      end
      if (weight_valid) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL weight_unexpected got=%0d want=none", $signed(weight_out));
        end else begin
          logic [DW-1:0] exp_w;
          exp_w = wq.pop_front();
          if (weight_out !== exp_w) begin
            bad++;
            $display("FAIL weight_value got=%0d want=%0d", $signed(weight_out), $signed(exp_w));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    for (int i = 0; i < 9; i++) win_in[i*DW +: DW] = $urandom;
  endtask

  task automatic do_start(input int n);
    num_windows = CW'(n);
    start = 1'b1;
    if (n != 0)
      for (int k = 0; k < NK; k++)
        for (int i = 0; i < 9; i++) wq.push_back(wmem[9*k + i]);
    $display("job start num_windows=%0d", n);
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({busy, done, kernel_idx, wmem_rd, wmem_addr, weight_valid, weight_out,
         win_in_ready, window_valid} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b rd=%b addr=%0d wv=%b wo=%0d rdy=%b winv=%b want=all 0",
               busy, done, wmem_rd, wmem_addr, weight_valid, weight_out, win_in_ready, window_valid);
    end
    total++;
    if (window_out !== win_in) begin
      bad++;
      $display("FAIL reset_window_follow got=%h want=%h", window_out, win_in);
    end
    Rst_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got busy=%b want=0", busy);
    end
  endtask

  // Job 1 (num_windows=3): load timing of kernel 0.
  task automatic test_single_load();
    win_in_valid = 1'b1;
    do_start(3);
    for (int j = 1; j <= 10; j++) begin
      total++;
      if (wmem_rd !== (j <= 9)) begin
        bad++;
        $display("FAIL load_rd T+%0d got=%b want=%b", j, wmem_rd, (j <= 9));
      end
      if (j <= 9) begin
        total++;
        if (wmem_addr !== AW'(j - 1)) begin
          bad++;
          $display("FAIL load_addr T+%0d got=%0d want=%0d", j, wmem_addr, j - 1);
        end
      end
      total++;
      if (weight_valid !== (j >= 2)) begin
        bad++;
        $display("FAIL load_wvalid T+%0d got=%b want=%b", j, weight_valid, (j >= 2));
      end
      total++;
      if (win_in_ready !== 1'b0 || window_valid !== 1'b0) begin
        bad++;
        $display("FAIL load_no_window T+%0d got rdy=%b wv=%b want=0 0", j, win_in_ready, window_valid);
      end
      tick();
    end
  endtask

  // Job 1 continued: exactly three windows, then ready stays low.
  task automatic test_window_gating();
    int win_base;
    int cyc;
    win_base = n_win;
    for (int j = 11; j <= 13; j++) begin
      total++;
      if (win_in_ready !== 1'b1 || window_valid !== 1'b1) begin
        bad++;
        $display("FAIL gate_accept T+%0d got rdy=%b wv=%b want=1 1", j, win_in_ready, window_valid);
      end
      tick();
    end
    cyc = 0;
    while (!wmem_rd && cyc < 60) begin
      total++;
      if (win_in_ready !== 1'b0 || window_valid !== 1'b0) begin
        bad++;
        $display("FAIL gate_closed cyc=%0d got rdy=%b wv=%b want=0 0", cyc, win_in_ready, window_valid);
      end
      tick();
      cyc++;
    end
    total++;
    if (!wmem_rd) begin
      bad++;
      $display("FAIL gate_timeout got=no reload want=reload");
    end
    total++;
    if (n_win - win_base !== 3) begin
      bad++;
      $display("FAIL gate_count got=%0d want=3", n_win - win_base);
    end
  endtask

  // Job 1 continued: kernel 1 reload after 3 results, then done once.
  task automatic test_two_kernels();
    int done_base;
    int cyc;
    done_base = n_done;
    total++;
    if (n_res !== 3) begin
      bad++;
      $display("FAIL reload_after_results got=%0d want=3", n_res);
    end
    total++;
    if (kernel_idx !== KW'(1)) begin
      bad++;
      $display("FAIL kernel_idx got=%0d want=1", kernel_idx);
    end
    for (int j = 0; j < 9; j++) begin
      total++;
      if (wmem_rd !== 1'b1 || wmem_addr !== AW'(9 + j)) begin
        bad++;
        $display("FAIL k1_addr got rd=%b addr=%0d want rd=1 addr=%0d", wmem_rd, wmem_addr, 9 + j);
      end
      tick();
    end
    cyc = 0;
    while (!done && cyc < 80) begin tick(); cyc++; end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL two_k_done_timeout got=0 want=1");
    end
    tick(); tick(); tick();
    total++;
    if (n_done - done_base !== 1) begin
      bad++;
      $display("FAIL done_count got=%0d want=1", n_done - done_base);
    end
    total++;
    if (n_res !== 6 || n_win !== 6) begin
      bad++;
      $display("FAIL job_totals got res=%0d win=%0d want=6 6", n_res, n_win);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_done got=%b want=0", busy);
    end
  endtask

  task automatic test_upstream_stalls();
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    int win_base;
    int cyc;
    win_base = n_win;
    win_in_valid = 1'b0;
    do_start(3);
    for (int j = 1; j <= 10; j++) tick();
    for (int p = 0; p < 6; p++) begin
      win_in_valid = pat[p][0];
      #1;
      total++;
      if (window_valid !== pat[p][0] || win_in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stall_step%0d got wv=%b rdy=%b want wv=%0d rdy=1", p, window_valid, win_in_ready, pat[p]);
      end
      tick();
    end
    win_in_valid = 1'b1;
    #1;
    total++;
    if (win_in_ready !== 1'b0 || window_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_third_accept got rdy=%b wv=%b want=0 0", win_in_ready, window_valid);
    end
    cyc = 0;
    while (!done && cyc < 120) begin tick(); cyc++; end
    total++;
    if (!done || n_win - win_base !== 6) begin
      bad++;
      $display("FAIL stall_job got done=%b win=%0d want done=1 win=6", done, n_win - win_base);
    end
    tick();
  endtask

  task automatic test_corner();
    int rd_base;
    int res_base;
    int win_base;
    int cyc;
    // Stray result in IDLE, then a zero-window job.
    stray_rv = 1'b1;
    tick();
    stray_rv = 1'b0;
    rd_base = n_rd;
    do_start(0);
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || wmem_rd !== 1'b0) begin
      bad++;
      $display("FAIL zero_job T+1 got done=%b busy=%b rd=%b want 1 1 0", done, busy, wmem_rd);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || n_rd !== rd_base) begin
      bad++;
      $display("FAIL zero_job_end got done=%b busy=%b reads=%0d want 0 0 0", done, busy, n_rd - rd_base);
    end
    // Job with a stray result and a second start during LOAD.
    res_base = n_res;
    win_base = n_win;
    win_in_valid = 1'b1;
    do_start(2);
    tick(); tick();
    num_windows = CW'(5);
    start = 1'b1;
    stray_rv = 1'b1;
    tick();
    start = 1'b0;
    stray_rv = 1'b0;
    cyc = 0;
    while (!(wmem_rd && wmem_addr == AW'(9)) && cyc < 60) begin tick(); cyc++; end
    total++;
    if (!(wmem_rd && wmem_addr == AW'(9)) || n_res - res_base !== 2) begin
      bad++;
      $display("FAIL stray_reload got model_results=%0d want=2", n_res - res_base);
    end
    total++;
    if (n_win - win_base !== 2) begin
      bad++;
      $display("FAIL busy_start_ignored got windows=%0d want=2", n_win - win_base);
    end
    cyc = 0;
    while (!done && cyc < 80) begin tick(); cyc++; end
    total++;
    if (!done || n_win - win_base !== 4) begin
      bad++;
      $display("FAIL corner_job got done=%b win=%0d want done=1 win=4", done, n_win - win_base);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int cyc;
    win_in_valid = 1'b1;
    do_start(3);
    for (int j = 1; j <= 11; j++) tick();
    #2;
    Rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, kernel_idx, wmem_rd, wmem_addr, weight_valid, weight_out,
         win_in_ready, window_valid} !== '0) begin
      bad++;
      $display("FAIL async_reset got busy=%b rdy=%b wv=%b addr=%0d want=all 0",
               busy, win_in_ready, window_valid, wmem_addr);
    end
    wq.delete();
    tick();
    Rst_n = 1'b1;
    tick();
    do_start(1);
    total++;
    if (wmem_rd !== 1'b1 || wmem_addr !== '0 || kernel_idx !== '0) begin
      bad++;
      $display("FAIL restart got rd=%b addr=%0d k=%0d want 1 0 0", wmem_rd, wmem_addr, kernel_idx);
    end
    cyc = 0;
    while (!done && cyc < 120) begin tick(); cyc++; end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL restart_done got=0 want=1");
    end
    tick();
    total++;
    if (wq.size() != 0) begin
      bad++;
      $display("FAIL weights_left got=%0d want=0", wq.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) wmem[i] = DW'(1000 + i);
    for (int i = 0; i < 9; i++) wmem[i] = DW'(i + 1);
    wmem[9]  = -32'sd20; wmem[10] = -32'sd8; wmem[11] = 32'sd6;
    wmem[12] = 32'sd0;   wmem[13] = -32'sd1; wmem[14] = -32'sd4;
    wmem[15] = 32'sd3;   wmem[16] = 32'sd2;  wmem[17] = 32'sd1;
    test_reset();
    test_single_load();
    test_window_gating();
    test_two_kernels();
    test_upstream_stalls();
    test_corner();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
